latch_capture_deser: RTL and testbench
======================================

# latch_capture_deser

Synchronous capture stage that sits directly downstream of the transparent data latch. Synchronizes the latch output and latch enable into the `clk` domain, samples the held bit each time the latch closes (enable high→low), assembles `WIDTH` samples into a word, and hands the word on with a valid/ready handshake. Also counts toggles of the latch output and flags dropped words.

## Interface
- `WIDTH`, 8, bits per assembled word (≥2)
- `SYNC_STAGES`, 2, synchronizer flops on `q_in` and `enable_in` (≥2)

- `clk` input 1, single clock; all state updates on rising edge
- `rst_n` input 1, reset, synchronous, active-low
- `q_in` input 1, latch output, asynchronous to `clk`
- `enable_in` input 1, latch enable, asynchronous to `clk`
- `out_data` output WIDTH, assembled word
- `out_valid` output 1, `out_data` holds an unconsumed word
- `out_ready` input 1, consumer accepts word when high with `out_valid`
- `edge_count` output 8, number of `q_in` transitions seen, saturating
- `overrun` output 1, sticky: a completed word was dropped

## Operation
- Synchronizers: `q_s`, `en_s` = last stage of each `SYNC_STAGES`-deep chain; `en_prev` = `en_s` delayed one cycle; `q_prev` = `q_s` delayed one cycle.
- Capture event: cycle where `en_prev==1 && en_s==0`. On it, `shift <= {shift[WIDTH-2:0], q_s}`, `bit_cnt <= bit_cnt+1`. First captured bit ends in MSB.
- `bit_cnt` width = clog2(WIDTH+1); wraps to 0 when a capture makes it reach WIDTH (word complete).
- Output FSM, two states: EMPTY (`out_valid=0`), FULL (`out_valid=1`).
  - EMPTY + word complete → load `out_data` with `{shift[WIDTH-2:0], q_s}`, go FULL.
  - FULL + `out_ready` + no completion → EMPTY; `out_data` holds last value.
  - FULL + `out_ready` + completion same cycle → load new word, stay FULL (no bubble, no overrun).
  - FULL + `!out_ready` + completion → new word discarded, `out_data` unchanged, `overrun <= 1`; shift/bit_cnt still restart at 0.
- `overrun` clears only on reset.
- Edge counter: `q_s != q_prev` → `edge_count <= edge_count+1` unless already 255 (holds 255). Counts regardless of `en_s`.
- Rising edge of `en_s` and cycles with `en_s` steady have no effect on shift path.
- Reset (`rst_n==0` at a rising edge): synchronizer flops, `en_prev`, `q_prev`, `shift`, `bit_cnt`, `out_data`, `edge_count` ← 0; `out_valid`, `overrun` ← 0; FSM ← EMPTY. Reset mid-word discards partial bits; next word starts from bit 0. Reset overrides all other events in that cycle.
- Because `en_prev`/`q_prev` reset to 0, no capture or edge is counted from reset release alone unless the synchronized input is 1 (a `q_in` held at 1 through reset release counts one edge).

## Timing
- Synchronizer latency: input change settled before edge k appears on `q_s`/`en_s` after edge k+SYNC_STAGES−1.
- Capture latency: `enable_in` falling before edge 0 → capture at edge SYNC_STAGES (default: 2nd edge); if it completes the word, `out_valid` high after that same edge.
- `q_in` must be stable for ≥SYNC_STAGES+1 cycles around the enable fall (guaranteed: latch holds while enable low).
- Minimum enable low and high time for guaranteed capture: SYNC_STAGES+1 cycles each; shorter pulses may be missed, never double-captured.
- Handshake: transfer on any edge with `out_valid && out_ready`; `out_data` stable while `out_valid && !out_ready`. `out_ready` may be high with `out_valid` low (ignored).
- `edge_count` updates one cycle after `q_s` changes.

## Test plan
- Reset: drive `rst_n=0` 3 cycles with inputs toggling → all outputs 0, `out_valid=0`, `overrun=0`; after release, no capture without an enable fall.
- Word assembly: 8 enable pulses (5 cycles high/5 low) with `q_in` = 1,0,1,0,0,1,0,1, `out_ready=1` → `out_data=8'hA5`, `out_valid` high one cycle, asserted 2 edges after 8th enable fall.
- Backpressure: `out_ready=0`, send 0xA5 then 0x3C → `out_data` stays 0xA5, `out_valid=1`, `overrun=1`; raise `out_ready` → one transfer, `out_valid=0`.
- Simultaneous accept/complete: `out_valid=1`, time `out_ready` on the completion edge of 0x3C → `out_data=0x3C`, `out_valid` stays 1, `overrun=0`.
- Edge counter: toggle `q_in` 300 times, slow enough to sync → `edge_count` reaches 255 and holds.
- Reset mid-word: 3 captures, reset, then 8 captures of 0xFF → `out_data=0xFF`, no stale bits.

Source files
------------

// File: rtl/latch_capture_deser.sv
// Capture stage behind a transparent data latch. The latch output and enable are
// synchronized into clk; the held bit is sampled on each enable fall and packed into words.
module latch_capture_deser #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             enable_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       edge_count,
  output logic             overrun
);

  // state | meaning
  // EMPTY | no unconsumed word, out_valid low
  // FULL  | out_data holds a word waiting for out_ready

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] q_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic                   q_s;
  logic                   en_s;
  logic                   q_prev;
  logic                   en_prev;
  logic [WIDTH-1:0]       shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   capture;
  logic                   complete;
  logic [WIDTH-1:0]       next_word;

  assign q_s       = q_sync[SYNC_STAGES-1];
  assign en_s      = en_sync[SYNC_STAGES-1];
  assign capture   = en_prev & ~en_s;
  assign complete  = capture && (bit_cnt == LAST_BIT);
  assign next_word = {shift[WIDTH-2:0], q_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sync  <= '0;
      en_sync <= '0;
      q_prev  <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      q_sync  <= {q_sync[SYNC_STAGES-2:0], q_in};
      en_sync <= {en_sync[SYNC_STAGES-2:0], enable_in};
      q_prev  <= q_s;
      en_prev <= en_s;
    end
  end

  // A completed word always restarts the counter, even when the word is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (capture) begin
      shift   <= next_word;
      bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            out_data  <= next_word;
            out_valid <= 1'b1;
            state     <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            if (out_ready) begin
              out_data <= next_word;
            end else begin
              overrun <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_count <= '0;
    end else if ((q_s != q_prev) && (edge_count != 8'hFF)) begin
      edge_count <= edge_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_latch_capture_deser.sv
// Bench for latch_capture_deser: directed vector table, random words against a
// word-queue / transition-count model, and hand-written backpressure and reset sequences.
module tb_latch_capture_deser;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       q_in = 1'b0;
  logic       enable_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] edge_count;
  logic       overrun;

  int         tests;
  int         fails;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       qcur;
  int         exp_edges;

  typedef struct {
    logic [7:0] word;
    int         hi;
    int         lo;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  latch_capture_deser #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q_in      (q_in),
    .enable_in (enable_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .edge_count(edge_count),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_edges();
    return (exp_edges > 255) ? 255 : exp_edges;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enable rises with the new bit, stays high hi cycles, then falls (returns at the fall).
  task automatic drive_bit(input logic b, input int hi);
    @(negedge clk);
    if (b !== qcur) exp_edges++;
    qcur      = b;
    q_in      = b;
    enable_in = 1'b1;
    repeat (hi) @(negedge clk);
    enable_in = 1'b0;
  endtask

  // MSB is sent first; returns right at the last enable fall.
  task automatic send_word(input logic [7:0] w, input int hi, input int lo);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      drive_bit(w[i], hi);
      if (i > 0) tick(lo - 1);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    q_in      = 1'b0;
    enable_in = 1'b0;
    qcur      = 1'b0;
    exp_edges = 0;
    tick(n);
    rst_n = 1'b1;
  endtask

  task automatic toggle_q(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      qcur = ~qcur;
      q_in = qcur;
      exp_edges++;
      tick(3);
    end
  endtask

  // Transfer monitor: values just after negedge are what the next rising edge samples.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL xfer: unexpected word %0h, none expected", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          fails++;
          $display("FAIL xfer: got %0h expected %0h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    qcur      = 1'b0;
    exp_edges = 0;

    vecs[0] = '{8'hA5, 5, 5, 8'hA5};
    vecs[1] = '{8'h00, 3, 3, 8'h00};
    vecs[2] = '{8'hFF, 4, 6, 8'hFF};
    vecs[3] = '{8'h3C, 6, 3, 8'h3C};
    vecs[4] = '{8'h81, 3, 7, 8'h81};

    // Reset with inputs toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      q_in      = i[0];
      enable_in = ~i[0];
      out_ready = i[0];
    end
    @(negedge clk);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_edge_count", 32'(edge_count), 32'h0);
    q_in      = 1'b0;
    enable_in = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    tick(6);
    check("post_rst_valid", 32'(out_valid), 32'h0);
    check("post_rst_edges", 32'(edge_count), 32'h0);

    // Directed words with out_ready held high
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].exp_data);
      send_word(vecs[v].word, vecs[v].hi, vecs[v].lo);
      tick(2);
      check("vec_valid_early", 32'(out_valid), 32'h0);
      tick(1);
      check("vec_valid", 32'(out_valid), 32'h1);
      check("vec_data", 32'(out_data), 32'(vecs[v].exp_data));
      tick(1);
      check("vec_valid_one_cycle", 32'(out_valid), 32'h0);
      check("vec_overrun", 32'(overrun), 32'h0);
    end
    check("vec_edge_count", 32'(edge_count), 32'(sat_edges()));

    // Random words and pulse widths
    for (int r = 0; r < 20; r++) begin
      logic [7:0] w;
      int hi;
      int lo;
      w  = 8'($urandom);
      hi = $urandom_range(3, 7);
      lo = $urandom_range(3, 7);
      exp_q.push_back(w);
      send_word(w, hi, lo);
      tick(3);
      check("rnd_valid", 32'(out_valid), 32'h1);
      check("rnd_data", 32'(out_data), 32'(w));
      tick(1);
    end
    check("rnd_edge_count", 32'(edge_count), 32'(sat_edges()));
    check("rnd_overrun", 32'(overrun), 32'h0);

    // Backpressure: second word dropped, overrun set
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 5, 5);
    tick(3);
    check("bp_valid1", 32'(out_valid), 32'h1);
    check("bp_data1", 32'(out_data), 32'hA5);
    check("bp_overrun1", 32'(overrun), 32'h0);
    send_word(8'h3C, 5, 5);
    tick(3);
    check("bp_valid2", 32'(out_valid), 32'h1);
    check("bp_data2", 32'(out_data), 32'hA5);
    check("bp_overrun2", 32'(overrun), 32'h1);
    tick(1);
    out_ready = 1'b1;
    tick(1);
    check("bp_drain_valid", 32'(out_valid), 32'h0);
    check("bp_drain_data", 32'(out_data), 32'hA5);
    check("bp_overrun_sticky", 32'(overrun), 32'h1);

    // Reset mid-word discards partial bits and clears overrun
    drive_bit(1'b1, 4);
    tick(3);
    drive_bit(1'b0, 4);
    tick(3);
    drive_bit(1'b1, 4);
    tick(4);
    do_reset(2);
    tick(1);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_edges", 32'(edge_count), 32'h0);
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 4, 4);
    tick(3);
    check("mid_rst_word_valid", 32'(out_valid), 32'h1);
    check("mid_rst_word_data", 32'(out_data), 32'hFF);
    tick(1);

    // Accept and completion on the same edge
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 4, 4);
    tick(3);
    check("sim_valid1", 32'(out_valid), 32'h1);
    check("sim_data1", 32'(out_data), 32'hA5);
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 4, 4);
    tick(2);
    check("sim_hold_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    tick(1);
    check("sim_valid2", 32'(out_valid), 32'h1);
    check("sim_data2", 32'(out_data), 32'h3C);
    check("sim_overrun", 32'(overrun), 32'h0);
    tick(1);
    check("sim_drain_valid", 32'(out_valid), 32'h0);

    // Edge counter up to and past saturation
    toggle_q(100);
    tick(4);
    check("edges_100", 32'(edge_count), 32'(sat_edges()));
    toggle_q(200);
    tick(4);
    check("edges_sat", 32'(edge_count), 32'd255);
    check("edges_no_capture", 32'(out_valid), 32'h0);

    tick(2);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
